// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Free-running VGA raster timing generator running on the pixel clock.
// It walks the raster one pixel per clock: active area first, then front
// porch, sync and back porch, both horizontally and vertically.
// Every output is registered. The decode is taken from the *next* position
// and flopped alongside it, so sx/sy and all strobes describe the same
// raster position with no relative skew.
//
// Ports
//   clk_pix     in   1      pixel clock (only clock)
//   rst         in   1      synchronous reset, active-high
//   clk_locked  in   1      PLL lock; low acts as a synchronous reset
//   sx          out  CORDW  horizontal position, 0..H_TOTAL-1
//   sy          out  CORDW  vertical position, 0..V_TOTAL-1
//   hsync       out  1      horizontal sync, active level HS_POL
//   vsync       out  1      vertical sync, active level VS_POL
//   de          out  1      data enable, high in the active area
//   frame       out  1      one-cycle strobe at (0,0)
//   line        out  1      one-cycle strobe at sx==0 on every line
//   frame_cnt   out  FCW    frames started since reset, wrapping
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_RES  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_RES  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int CORDW  = 10,
  parameter int FCW    = 16
) (
  input  logic             clk_pix,
  input  logic             rst,
  input  logic             clk_locked,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             frame,
  output logic             line,
  output logic [FCW-1:0]   frame_cnt
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  // All raster boundaries are held at coordinate width so every compare is
  // a plain unsigned compare between equally sized operands.
  localparam logic [CORDW-1:0] H_LAST   = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST   = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_ACTIVE = CORDW'(H_RES);
  localparam logic [CORDW-1:0] V_ACTIVE = CORDW'(V_RES);
  localparam logic [CORDW-1:0] HS_START = CORDW'(H_RES + H_FP);
  localparam logic [CORDW-1:0] HS_END   = CORDW'(H_RES + H_FP + H_SYNC);
  localparam logic [CORDW-1:0] VS_START = CORDW'(V_RES + V_FP);
  localparam logic [CORDW-1:0] VS_END   = CORDW'(V_RES + V_FP + V_SYNC);

  // Loss of PLL lock is treated exactly like an explicit reset.
  logic reset_req;
  assign reset_req = rst || !clk_locked;

  logic [CORDW-1:0] sx_q, sx_d;
  logic [CORDW-1:0] sy_q, sy_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             de_q, de_d;
  logic             frame_q, frame_d;
  logic             line_q, line_d;
  logic [FCW-1:0]   frame_cnt_q, frame_cnt_d;

  // Next raster position. The reset position is the last pixel of the
  // frame, so the first enabled edge naturally lands on (0,0) and fires
  // the frame strobe through the normal decode path.
  always_comb begin
    sx_d = sx_q + CORDW'(1);
    sy_d = sy_q;
    if (sx_q == H_LAST) begin
      sx_d = '0;
      if (sy_q == V_LAST) begin
        sy_d = '0;
      end else begin
        sy_d = sy_q + CORDW'(1);
      end
    end
  end

  // Decode of the next position, registered together with it.
  always_comb begin
    de_d        = (sx_d < H_ACTIVE) && (sy_d < V_ACTIVE);
    hsync_d     = ((sx_d >= HS_START) && (sx_d < HS_END)) ? HS_POL : ~HS_POL;
    vsync_d     = ((sy_d >= VS_START) && (sy_d < VS_END)) ? VS_POL : ~VS_POL;
    line_d      = (sx_d == '0);
    frame_d     = (sx_d == '0) && (sy_d == '0);
    frame_cnt_d = frame_cnt_q;
    if (frame_d) begin
      frame_cnt_d = frame_cnt_q + FCW'(1);
    end
  end

  always_ff @(posedge clk_pix) begin
    if (reset_req) begin
      sx_q        <= H_LAST;
      sy_q        <= V_LAST;
      hsync_q     <= ~HS_POL;
      vsync_q     <= ~VS_POL;
      de_q        <= 1'b0;
      frame_q     <= 1'b0;
      line_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      de_q        <= de_d;
      frame_q     <= frame_d;
      line_q      <= line_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign sx        = sx_q;
  assign sy        = sy_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign de        = de_q;
  assign frame     = frame_q;
  assign line      = line_q;
  assign frame_cnt = frame_cnt_q;

endmodule
